servo_pwm_gen: RTL and testbench

- Downstream consumer of the 8-bit arm position counter. Converts the 8-bit `pos` value (0..255) into a fixed-period servo PWM waveform for one joint.
- Samples `pos` only at frame boundaries, so a mid-frame counter step never produces a glitched pulse.
- One instance per joint; the output drives the servo pin directly.

---
 rtl/servo_pwm_gen.sv | 107 ++++++++++
 tb/tb_servo_pwm_gen.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_gen.sv
// rtl/servo_pwm_gen.sv - fixed-period servo PWM generator driven by an 8-bit position
module servo_pwm_gen #(
  parameter int TICK_DIV     = 50,
  parameter int PERIOD_TICKS = 20000,
  parameter int MIN_PULSE    = 1000,
  parameter int STEP         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] pos,
  output logic       pwm_out,
  output logic       frame_start,
  output logic [7:0] pos_latched,
  output logic       active
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [15:0] DIV_LAST    = 16'(TICK_DIV - 1);
  localparam logic [15:0] PERIOD_LAST = 16'(PERIOD_TICKS - 1);
  localparam logic [16:0] PULSE_MAX   = 17'(PERIOD_TICKS - 1);
  localparam logic [16:0] MIN_W       = 17'(MIN_PULSE);
  localparam logic [16:0] STEP_W      = 17'(STEP);
  localparam logic [7:0]  POS_RESET   = 8'd45;

  // High time in ticks for a position, clamped so the pulse always ends inside the frame
  function automatic logic [16:0] pulse_of(input logic [7:0] p);
    logic [16:0] raw;
    raw = MIN_W + (17'(p) * STEP_W);
    if (raw > PULSE_MAX) raw = PULSE_MAX;
    return raw;
  endfunction

  state_t      state, state_n;
  logic [15:0] presc, presc_n;
  logic [15:0] tcnt, tcnt_n;
  logic [7:0]  pos_l_n;
  logic        fs_n, pwm_n;
  logic        tick, frame_end;
  logic [16:0] pulse_cur, pulse_new;

  assign pulse_cur = pulse_of(pos_latched);
  assign pulse_new = pulse_of(pos);
  assign tick      = (state == RUN) && (presc == DIV_LAST);
  assign frame_end = tick && (tcnt == PERIOD_LAST);
  assign active    = (state == RUN);

  // State and datapath registers; reset forces the pin low immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      presc       <= 16'd0;
      tcnt        <= 16'd0;
      pos_latched <= POS_RESET;
      frame_start <= 1'b0;
      pwm_out     <= 1'b0;
    end else begin
      state       <= state_n;
      presc       <= presc_n;
      tcnt        <= tcnt_n;
      pos_latched <= pos_l_n;
      frame_start <= fs_n;
      pwm_out     <= pwm_n;
    end
  end

  // Next-state: frames restart back-to-back; enable and pos only matter at frame boundaries
  always_comb begin
    state_n = state;
    presc_n = presc;
    tcnt_n  = tcnt;
    pos_l_n = pos_latched;
    fs_n    = 1'b0;
    pwm_n   = 1'b0;
    case (state)
      IDLE: begin
        presc_n = 16'd0;
        tcnt_n  = 16'd0;
        if (enable) begin
          state_n = RUN;
          pos_l_n = pos;
          fs_n    = 1'b1;
          pwm_n   = (pulse_new != 17'd0);
        end
      end
      RUN: begin
        presc_n = tick ? 16'd0 : presc + 16'd1;
        if (frame_end) begin
          tcnt_n = 16'd0;
          if (enable) begin
            pos_l_n = pos;
            fs_n    = 1'b1;
            pwm_n   = (pulse_new != 17'd0);
          end else begin
            state_n = IDLE;
          end
        end else begin
          if (tick) tcnt_n = tcnt + 16'd1;
          pwm_n = ({1'b0, tcnt_n} < pulse_cur);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb/tb_servo_pwm_gen.sv - self-checking bench for servo_pwm_gen
module tb_servo_pwm_gen;

  localparam int FRAME = 1200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       en_c = 1'b0;
  logic [7:0] pos = 8'd45;
  logic [7:0] pos_c = 8'd255;

  logic       pwm0, fs0, act0, pwm1, fs1, act1;
  logic [7:0] lat0, lat1;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  servo_pwm_gen #(.TICK_DIV(2), .PERIOD_TICKS(600), .MIN_PULSE(20), .STEP(2)) dut (
    .clk(clk), .rst(rst), .enable(en), .pos(pos),
    .pwm_out(pwm0), .frame_start(fs0), .pos_latched(lat0), .active(act0)
  );

  servo_pwm_gen #(.TICK_DIV(2), .PERIOD_TICKS(600), .MIN_PULSE(20), .STEP(3)) dut_c (
    .clk(clk), .rst(rst), .enable(en_c), .pos(pos_c),
    .pwm_out(pwm1), .frame_start(fs1), .pos_latched(lat1), .active(act1)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // High time in clk cycles for a latched position
  function automatic int high_cycles(input int lat, input int step);
    int t;
    t = 20 + lat * step;
    if (t > 599) t = 599;
    return t * 2;
  endfunction

  // Frame-level model: which cycle of the frame we are in and what was latched
  bit m_run [2];
  int m_lat [2];
  int m_cyc [2];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_run[k] = 1'b0;
        m_lat[k] = 45;
        m_cyc[k] = 0;
      end else if (!m_run[k]) begin
        if ((k == 0) ? en : en_c) begin
          m_run[k] = 1'b1;
          m_lat[k] = (k == 0) ? int'(pos) : int'(pos_c);
          m_cyc[k] = 0;
        end
      end else if (m_cyc[k] == FRAME - 1) begin
        m_cyc[k] = 0;
        if ((k == 0) ? en : en_c) m_lat[k] = (k == 0) ? int'(pos) : int'(pos_c);
        else m_run[k] = 1'b0;
      end else begin
        m_cyc[k] = m_cyc[k] + 1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      check("pwm0", int'(pwm0), int'(m_run[0] && m_cyc[0] < high_cycles(m_lat[0], 2)));
      check("fs0", int'(fs0), int'(m_run[0] && m_cyc[0] == 0));
      check("act0", int'(act0), int'(m_run[0]));
      check("lat0", int'(lat0), m_lat[0]);
      check("pwm1", int'(pwm1), int'(m_run[1] && m_cyc[1] < high_cycles(m_lat[1], 3)));
      check("fs1", int'(fs1), int'(m_run[1] && m_cyc[1] == 0));
      check("act1", int'(act1), int'(m_run[1]));
      check("lat1", int'(lat1), m_lat[1]);
    end
  end

  task automatic wait_fs(input int which);
    int n;
    n = 0;
    while (((which == 0) ? fs0 : fs1) !== 1'b1 && n < 2500) begin
      @(negedge clk);
      n++;
    end
    check("wait_frame_start", int'(n < 2500), 1);
  endtask

  // Called on a frame's first cycle; counts high cycles over one frame, optionally
  // changing pos (kind 1) or enable (kind 2) at cycle chg_at
  task automatic measure(input int which, input int exp_high, input string name,
                         input int chg_at, input int kind, input int val);
    int hi;
    hi = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (((which == 0) ? pwm0 : pwm1) === 1'b1) hi++;
      if (i == chg_at && kind == 1) pos = 8'(val);
      if (i == chg_at && kind == 2) en = val[0];
      @(negedge clk);
    end
    check(name, hi, exp_high);
  endtask

  initial begin
    #1 rst = 1'b1;
    cmp_on = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(pwm0), 0);
    check("rst_fs", int'(fs0), 0);
    check("rst_act", int'(act0), 0);
    check("rst_lat", int'(lat0), 45);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_act", int'(act0), 0);

    en = 1'b1; en_c = 1'b1; pos = 8'd45;
    wait_fs(0);
    check("f1_lat", int'(lat0), 45);
    check("f1_act", int'(act0), 1);
    pos = 8'd0;
    measure(0, 220, "high_pos45", -1, 0, 0);
    check("period_fs", int'(fs0), 1);
    check("f2_lat", int'(lat0), 0);
    pos = 8'd255;
    measure(0, 40, "high_pos0", -1, 0, 0);
    check("f3_lat", int'(lat0), 255);
    pos = 8'd100;
    measure(0, 1060, "high_pos255", -1, 0, 0);
    check("f4_lat", int'(lat0), 100);
    measure(0, 440, "high_midchange", 50, 1, 200);
    check("f5_lat", int'(lat0), 200);
    pos = 8'd45;
    measure(0, 840, "high_pos200", -1, 0, 0);
    check("f6_lat", int'(lat0), 45);
    measure(0, 220, "high_en_drop", 300, 2, 0);
    check("drop_act", int'(act0), 0);
    check("drop_pwm", int'(pwm0), 0);
    check("drop_fs", int'(fs0), 0);
    repeat (5) @(negedge clk);
    check("idle_hold", int'(act0), 0);

    pos = 8'd100; en = 1'b1;
    @(negedge clk);
    check("reen_fs", int'(fs0), 1);
    check("reen_pwm", int'(pwm0), 1);
    check("reen_lat", int'(lat0), 100);
    repeat (100) @(negedge clk);
    check("pre_rst_pwm", int'(pwm0), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm", int'(pwm0), 0);
    check("async_rst_lat", int'(lat0), 45);
    check("async_rst_act", int'(act0), 0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_idle", int'(act0), 0);
    check("post_rst_pwm", int'(pwm0), 0);
    pos = 8'd45; en = 1'b1;
    @(negedge clk);
    check("post_rst_start", int'(fs0), 1);
    check("post_rst_lat", int'(lat0), 45);

    wait_fs(1);
    measure(1, 1198, "clamp_high", -1, 0, 0);
    check("clamp_next_fs", int'(fs1), 1);

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
